divisor_arbiter: RTL and testbench
==================================

# divisor_arbiter

Round-robin controller that shares one combinational 4-bit `Divisor` datapath between two requesters. Each requester presents dividend/divisor on a valid/ready handshake. The block latches the accepted operands, drives them onto the shared divider, and registers quotient/remainder. It returns them on a per-requester response handshake. Divide-by-zero is trapped here rather than in the datapath.

## Interface
Parameters:
- `WIDTH`, 4, operand and result width; must match the attached `Divisor`.

Ports:
- `clock`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `req0_valid`, `req1_valid`  in  1  request present from requester i.
- `req0_ready`, `req1_ready`  out  1  request accepted this cycle when high with valid.
- `req0_dividend`, `req1_dividend`  in  WIDTH  dividend from requester i.
- `req0_divisor`, `req1_divisor`  in  WIDTH  divisor from requester i.
- `rsp0_valid`, `rsp1_valid`  out  1  result available for requester i.
- `rsp0_ready`, `rsp1_ready`  in  1  requester i consumes result.
- `rsp0_quotient`, `rsp1_quotient`  out  WIDTH  registered quotient.
- `rsp0_remainder`, `rsp1_remainder`  out  WIDTH  registered remainder.
- `rsp0_divzero`, `rsp1_divzero`  out  1  divisor was zero.
- `div_dividend`, `div_divisor`  out  WIDTH  operands to shared `Divisor`.
- `div_quotient`, `div_remainder`  in  WIDTH  results from shared `Divisor`.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, CALC, RESP. Reset state is IDLE.
- IDLE:
  - Grant selection is combinational. With both valid, the grant goes to the requester ≠ `last_grant`. With one valid, the grant goes to that requester.
  - `reqN_ready` = (state==IDLE) && grant==N. At most one ready is high.
  - On the valid&&ready edge: latch dividend, divisor and grant id into operand registers; set `last_grant` to the grant id; go to CALC.
- CALC, one cycle:
  - `div_dividend`/`div_divisor` are driven from the operand registers at all times.
  - On the exiting edge, capture results.
  - If divisor≠0: quotient=`div_quotient`, remainder=`div_remainder`, divzero=0.
  - If divisor==0: quotient=all ones (15), remainder=latched dividend, divzero=1. Divider outputs are ignored.
  - Go to RESP.
- RESP:
  - `rspN_valid` is high only for the latched id.
  - Result outputs hold stable until `rspN_ready`.
  - On the valid&&ready edge, go to IDLE.
- Results are presented on both rsp buses from one shared result register. Only the owning `rspN_valid` is high.
- Requester rule: operands stay stable while valid && !ready. The block does not check this.
- A requester may hold `req_valid` continuously. Fairness comes from `last_grant` alternation.

## Timing
- Reset values, next edge after `reset`=1:
  - state=IDLE, `last_grant`=1, so req0 wins the first tie.
  - Operand and result registers = 0, so `div_*`=0 and `rsp*_quotient`/`remainder`=0.
  - `rsp*_valid`=0, `rsp*_divzero`=0, `busy`=0.
  - `req*_ready`=0 while `reset` is high.
- Reset mid-operation, in CALC or RESP: the transaction is dropped, no response is issued, and the next cycle is IDLE.
- Latency:
  - Accept edge at cycle 0.
  - CALC during cycle 1.
  - `rsp_valid` high from cycle 2.
  - Minimum 3 cycles per operation, i.e. RESP consumed in cycle 2 and the next accept in cycle 3.
- No request is accepted during CALC or RESP. Ready is low and requests wait.
- Response and a new request in the same cycle: the new request is not accepted until the cycle after returning to IDLE.
- `rsp_ready` asserted early with no `rsp_valid` has no effect.

## Test plan
- **Single request:** req0 15/2 alone after reset → `req0_ready`=1 in cycle 0; `rsp0_valid`=1 in cycle 2 with q=7, r=1, divzero=0; `rsp1_valid` stays 0.
- **Simultaneous requests:** req0 9/3 and req1 14/4 in the same cycle after reset → req0 served first with q=3, r=0. req1 is then accepted with q=3, r=2. Total of 6 cycles with `rsp_ready` tied high.
- **Divide by zero:** req1 5/0 → `rsp1_divzero`=1, q=15, r=5.
- **Backpressure:** req0 12/5 with `rsp0_ready` low for 4 cycles → `rsp0_valid` held. q=2 and r=2 stay stable. `req1_ready` stays 0 while req1 is valid. Release `rsp0_ready` → IDLE on the next edge.
- **Reset mid-CALC:** accept req0 7/2, assert `reset` in cycle 1 → no `rsp0_valid` ever. All outputs are at reset values and `busy`=0 after the edge.
- **Fairness:** req0 and req1 held valid continuously for 6 operations → grants alternate 0,1,0,1,0,1 with correct results each time.

Source files
------------

// File: rtl/divisor_arbiter.sv
// divisor_arbiter
// Round-robin front end that shares one combinational divider between two
// requesters. A granted request is latched, presented to the divider for one
// cycle, and the registered result is returned on the owning response port.
// Divide-by-zero is detected here: quotient all ones, remainder = dividend.
//
// Ports
//   clock, reset                 clock, synchronous active-high reset
//   reqN_valid/ready             request handshake (N = 0, 1)
//   reqN_dividend/divisor        request operands
//   rspN_valid/ready             response handshake
//   rspN_quotient/remainder      shared registered result
//   rspN_divzero                 divisor of the returned result was zero
//   div_dividend/div_divisor     operands to the external divider
//   div_quotient/div_remainder   results from the external divider
//   busy                         high whenever the FSM is not idle
//   dbg_state                    current FSM state (0 IDLE, 1 CALC, 2 RESP)
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high. Ready never depends on anything the same requester does
// after valid is raised, and a requester keeps its operands stable while
// valid is high and ready is low. Responses hold their data until taken.
module divisor_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_dividend,
  input  logic [WIDTH-1:0] req0_divisor,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_dividend,
  input  logic [WIDTH-1:0] req1_divisor,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_quotient,
  output logic [WIDTH-1:0] rsp0_remainder,
  output logic             rsp0_divzero,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_quotient,
  output logic [WIDTH-1:0] rsp1_remainder,
  output logic             rsp1_divzero,
  output logic [WIDTH-1:0] div_dividend,
  output logic [WIDTH-1:0] div_divisor,
  input  logic [WIDTH-1:0] div_quotient,
  input  logic [WIDTH-1:0] div_remainder,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_last_grant;
  logic             r_id;
  logic [WIDTH-1:0] r_op_dividend;
  logic [WIDTH-1:0] r_op_divisor;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_divzero;
  logic             r_rsp0_valid;
  logic             r_rsp1_valid;
  logic             r_busy;

  logic             w_any_valid;
  logic             w_grant;
  logic             w_accept;
  logic             w_rsp_take;
  logic [WIDTH-1:0] w_sel_dividend;
  logic [WIDTH-1:0] w_sel_divisor;

  // On a tie the requester that was not served last wins; otherwise the
  // single valid requester wins (req1_valid alone selects 1).
  assign w_any_valid = req0_valid | req1_valid;
  assign w_grant     = (req0_valid & req1_valid) ? ~r_last_grant : req1_valid;

  // Ready is held low during reset so nothing is accepted on a reset edge.
  assign req0_ready = !reset && (r_state == IDLE) && w_any_valid && !w_grant;
  assign req1_ready = !reset && (r_state == IDLE) && w_any_valid &&  w_grant;

  assign w_accept   = (req0_valid & req0_ready) | (req1_valid & req1_ready);
  assign w_rsp_take = (r_rsp0_valid & rsp0_ready) | (r_rsp1_valid & rsp1_ready);

  assign w_sel_dividend = w_grant ? req1_dividend : req0_dividend;
  assign w_sel_divisor  = w_grant ? req1_divisor  : req0_divisor;

  assign div_dividend = r_op_dividend;
  assign div_divisor  = r_op_divisor;

  // One result register feeds both response buses; only the owner's valid
  // is raised.
  assign rsp0_valid     = r_rsp0_valid;
  assign rsp1_valid     = r_rsp1_valid;
  assign rsp0_quotient  = r_quotient;
  assign rsp1_quotient  = r_quotient;
  assign rsp0_remainder = r_remainder;
  assign rsp1_remainder = r_remainder;
  assign rsp0_divzero   = r_divzero;
  assign rsp1_divzero   = r_divzero;
  assign busy           = r_busy;
  assign dbg_state      = r_state;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= IDLE;
      r_last_grant  <= 1'b1;
      r_id          <= 1'b0;
      r_op_dividend <= '0;
      r_op_divisor  <= '0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_divzero     <= 1'b0;
      r_rsp0_valid  <= 1'b0;
      r_rsp1_valid  <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op_dividend <= w_sel_dividend;
            r_op_divisor  <= w_sel_divisor;
            r_id          <= w_grant;
            r_last_grant  <= w_grant;
            r_busy        <= 1'b1;
            r_state       <= CALC;
          end
        end
        CALC: begin
          // The divider output is meaningless for a zero divisor, so the
          // trapped result is built from the latched dividend instead.
          if (r_op_divisor == '0) begin
            r_quotient  <= '1;
            r_remainder <= r_op_dividend;
            r_divzero   <= 1'b1;
          end else begin
            r_quotient  <= div_quotient;
            r_remainder <= div_remainder;
            r_divzero   <= 1'b0;
          end
          r_rsp0_valid <= (r_id == 1'b0);
          r_rsp1_valid <= (r_id == 1'b1);
          r_state      <= RESP;
        end
        RESP: begin
          if (w_rsp_take) begin
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divisor_arbiter.sv
// Testbench for divisor_arbiter: models the attached divider, records each
// accepted request's expected result in a queue and checks responses.
module tb_divisor_arbiter;

  logic       clock = 1'b0;
  logic       reset;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0] req0_dividend, req0_divisor, req1_dividend, req1_divisor;
  logic       rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [3:0] rsp0_quotient, rsp0_remainder, rsp1_quotient, rsp1_remainder;
  logic       rsp0_divzero, rsp1_divzero;
  logic [3:0] div_dividend, div_divisor, div_quotient, div_remainder;
  logic       busy;
  logic [1:0] dbg_state;

  // expected entry: {id, divzero, quotient[3:0], remainder[3:0]}
  logic [9:0] exp_q[$];
  int compared   = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  divisor_arbiter #(.WIDTH(4)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_dividend(req0_dividend), .req0_divisor(req0_divisor),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_dividend(req1_dividend), .req1_divisor(req1_divisor),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_quotient(rsp0_quotient), .rsp0_remainder(rsp0_remainder),
    .rsp0_divzero(rsp0_divzero),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_quotient(rsp1_quotient), .rsp1_remainder(rsp1_remainder),
    .rsp1_divzero(rsp1_divzero),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .busy(busy), .dbg_state(dbg_state)
  );

  // Divider model; returns junk for a zero divisor so the trap is visible.
  assign div_quotient  = (div_divisor == 4'd0) ? 4'h6 : div_dividend / div_divisor;
  assign div_remainder = (div_divisor == 4'd0) ? 4'h9 : div_dividend % div_divisor;

  function automatic logic [9:0] model(input logic id, input logic [3:0] a, input logic [3:0] b);
    if (b == 4'd0) return {id, 1'b1, 4'hF, a};
    return {id, 1'b0, a / b, a % b};
  endfunction

  function automatic logic [9:0] obs();
    if (rsp1_valid) return {1'b1, rsp1_divzero, rsp1_quotient, rsp1_remainder};
    return {1'b0, rsp0_divzero, rsp0_quotient, rsp0_remainder};
  endfunction

  // Scoreboard push: every accepted request.
  always @(negedge clock) begin
    if (req0_valid && req0_ready) exp_q.push_back(model(1'b0, req0_dividend, req0_divisor));
    if (req1_valid && req1_ready) exp_q.push_back(model(1'b1, req1_dividend, req1_divisor));
  end

  task automatic clear_inputs();
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    req0_dividend = 0; req0_divisor = 0; req1_dividend = 0; req1_divisor = 0;
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1; clear_inputs();
    @(posedge clock); @(posedge clock); #1;
    reset = 0;
    exp_q.delete();
  endtask

  task automatic wait_rsp(input int max_cyc, output bit ok);
    ok = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clock);
      if (rsp0_valid || rsp1_valid) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    logic [9:0] got;
    @(posedge clock); #1;
    reset = 1; clear_inputs();
    req0_valid = 1; req0_dividend = 4'd3; req0_divisor = 4'd1;
    @(negedge clock);
    compared++;
    if (req0_ready !== 1'b0) begin $display("FAIL reset_ready: got %b want 0", req0_ready); mismatched++; end
    @(posedge clock); #1;
    @(negedge clock);
    compared++;
    if (dbg_state !== 2'd0 || busy !== 1'b0) begin
      $display("FAIL reset_state: state %0d busy %b want 0 0", dbg_state, busy); mismatched++;
    end
    compared++;
    if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
      $display("FAIL reset_rsp_valid: got %b%b want 00", rsp0_valid, rsp1_valid); mismatched++;
    end
    got = {1'b0, rsp0_divzero, rsp0_quotient, rsp0_remainder};
    compared++;
    if (got !== 10'h000 || div_dividend !== 4'd0 || div_divisor !== 4'd0) begin
      $display("FAIL reset_regs: rsp %h div %h/%h want 000 0/0", got, div_dividend, div_divisor); mismatched++;
    end
    @(posedge clock); #1;
    reset = 0; clear_inputs();
    exp_q.delete();
  endtask

  task automatic test_single();
    logic [9:0] e;
    do_reset();
    req0_valid = 1; req0_dividend = 4'd15; req0_divisor = 4'd2; rsp0_ready = 1;
    @(negedge clock);
    compared++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      $display("FAIL single_ready: got %b%b want 10", req0_ready, req1_ready); mismatched++;
    end
    @(posedge clock); #1; req0_valid = 0;
    @(negedge clock);
    compared++;
    if (busy !== 1'b1 || rsp0_valid !== 1'b0 || div_dividend !== 4'd15) begin
      $display("FAIL single_calc: busy %b rsp0_valid %b div_dividend %0d want 1 0 15", busy, rsp0_valid, div_dividend);
      mismatched++;
    end
    @(posedge clock); #1;
    @(negedge clock);
    compared++;
    if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0) begin
      $display("FAIL single_rsp_valid: got %b%b want 10", rsp0_valid, rsp1_valid); mismatched++;
    end
    compared++;
    if (exp_q.size() == 0) begin $display("FAIL single_result: empty expected queue"); mismatched++; end
    else begin
      e = exp_q.pop_front();
      if (obs() !== e) begin $display("FAIL single_result: got %h want %h", obs(), e); mismatched++; end
    end
    @(posedge clock); #1;
    @(negedge clock);
    compared++;
    if (busy !== 1'b0 || rsp0_valid !== 1'b0) begin
      $display("FAIL single_done: busy %b rsp0_valid %b want 0 0", busy, rsp0_valid); mismatched++;
    end
    clear_inputs();
  endtask

  task automatic test_simultaneous();
    logic [9:0] e;
    int acc1_n = -1, rsp0_n = -1, rsp1_n = -1;
    bit clear1 = 0;
    do_reset();
    req0_valid = 1; req0_dividend = 4'd9;  req0_divisor = 4'd3;
    req1_valid = 1; req1_dividend = 4'd14; req1_divisor = 4'd4;
    rsp0_ready = 1; rsp1_ready = 1;
    @(negedge clock);
    compared++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      $display("FAIL simul_first_grant: got %b%b want 10", req0_ready, req1_ready); mismatched++;
    end
    for (int n = 1; n <= 6; n++) begin
      @(posedge clock); #1;
      if (n == 1) req0_valid = 0;
      if (clear1) begin req1_valid = 0; clear1 = 0; end
      @(negedge clock);
      if (req1_valid && req1_ready && acc1_n < 0) begin acc1_n = n; clear1 = 1; end
      if (rsp0_valid && rsp0_n < 0) rsp0_n = n;
      if (rsp1_valid && rsp1_n < 0) rsp1_n = n;
      if (rsp0_valid || rsp1_valid) begin
        compared++;
        if (exp_q.size() == 0) begin $display("FAIL simul_result: empty expected queue"); mismatched++; end
        else begin
          e = exp_q.pop_front();
          if (obs() !== e) begin $display("FAIL simul_result: got %h want %h", obs(), e); mismatched++; end
        end
      end
      if (n == 6) begin
        compared++;
        if (busy !== 1'b0) begin $display("FAIL simul_idle_c6: busy %b want 0", busy); mismatched++; end
      end
    end
    compared++;
    if (rsp0_n !== 2 || acc1_n !== 3 || rsp1_n !== 5) begin
      $display("FAIL simul_timing: rsp0 c%0d acc1 c%0d rsp1 c%0d want c2 c3 c5", rsp0_n, acc1_n, rsp1_n);
      mismatched++;
    end
    clear_inputs();
  endtask

  task automatic test_divzero();
    logic [9:0] e;
    bit ok;
    do_reset();
    req1_valid = 1; req1_dividend = 4'd5; req1_divisor = 4'd0; rsp1_ready = 1;
    @(negedge clock);
    @(posedge clock); #1; req1_valid = 0;
    wait_rsp(8, ok);
    compared++;
    if (!ok) begin $display("FAIL divzero_timeout: no response within 8 cycles"); mismatched++; end
    else if (exp_q.size() == 0) begin $display("FAIL divzero_result: empty expected queue"); mismatched++; end
    else begin
      e = exp_q.pop_front();
      if (obs() !== e) begin $display("FAIL divzero_result: got %h want %h", obs(), e); mismatched++; end
    end
    @(posedge clock); #1;
    clear_inputs();
  endtask

  task automatic test_backpressure();
    logic [9:0] e;
    bit ok;
    do_reset();
    req0_valid = 1; req0_dividend = 4'd12; req0_divisor = 4'd5;
    @(negedge clock);
    compared++;
    if (req0_ready !== 1'b1) begin $display("FAIL bp_accept: req0_ready %b want 1", req0_ready); mismatched++; end
    @(posedge clock); #1;
    req0_valid = 0;
    req1_valid = 1; req1_dividend = 4'd3; req1_divisor = 4'd1;
    wait_rsp(6, ok);
    compared++;
    if (!ok) begin $display("FAIL bp_timeout: no response within 6 cycles"); mismatched++; end
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin @(posedge clock); #1; @(negedge clock); end
      compared++;
      if (rsp0_valid !== 1'b1 || req1_ready !== 1'b0 || exp_q.size() == 0 || obs() !== exp_q[0]) begin
        $display("FAIL bp_hold%0d: rsp0_valid %b req1_ready %b data %h want 1 0 %h",
                 k, rsp0_valid, req1_ready, obs(), (exp_q.size() > 0) ? exp_q[0] : 10'h0);
        mismatched++;
      end
    end
    @(posedge clock); #1; rsp0_ready = 1;
    @(negedge clock);
    compared++;
    if (exp_q.size() == 0) begin $display("FAIL bp_result: empty expected queue"); mismatched++; end
    else begin
      e = exp_q.pop_front();
      if (obs() !== e || rsp0_valid !== 1'b1) begin
        $display("FAIL bp_result: got %h valid %b want %h valid 1", obs(), rsp0_valid, e); mismatched++;
      end
    end
    @(posedge clock); #1;
    @(negedge clock);
    compared++;
    if (busy !== 1'b0 || req1_ready !== 1'b1) begin
      $display("FAIL bp_release: busy %b req1_ready %b want 0 1", busy, req1_ready); mismatched++;
    end
    @(posedge clock); #1; req1_valid = 0; rsp1_ready = 1;
    wait_rsp(6, ok);
    compared++;
    if (!ok) begin $display("FAIL bp_req1_timeout: no response within 6 cycles"); mismatched++; end
    else if (exp_q.size() == 0) begin $display("FAIL bp_req1_result: empty expected queue"); mismatched++; end
    else begin
      e = exp_q.pop_front();
      if (obs() !== e) begin $display("FAIL bp_req1_result: got %h want %h", obs(), e); mismatched++; end
    end
    @(posedge clock); #1;
    clear_inputs();
  endtask

  task automatic test_reset_mid_calc();
    bit seen = 0;
    do_reset();
    req0_valid = 1; req0_dividend = 4'd7; req0_divisor = 4'd2; rsp0_ready = 1;
    @(negedge clock);
    @(posedge clock); #1; req0_valid = 0; reset = 1;
    @(negedge clock);
    compared++;
    if (dbg_state !== 2'd1) begin $display("FAIL midcalc_in_calc: state %0d want 1", dbg_state); mismatched++; end
    @(posedge clock); #1; reset = 0;
    @(negedge clock);
    compared++;
    if (busy !== 1'b0 || dbg_state !== 2'd0 || rsp0_valid !== 1'b0 || rsp0_quotient !== 4'd0 ||
        rsp0_remainder !== 4'd0 || div_dividend !== 4'd0 || div_divisor !== 4'd0) begin
      $display("FAIL midcalc_reset_vals: busy %b state %0d v %b q %0d r %0d div %0d/%0d want all 0",
               busy, dbg_state, rsp0_valid, rsp0_quotient, rsp0_remainder, div_dividend, div_divisor);
      mismatched++;
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (rsp0_valid || rsp1_valid) seen = 1;
    end
    compared++;
    if (seen !== 1'b0) begin $display("FAIL midcalc_no_rsp: got response 1 want 0"); mismatched++; end
    exp_q.delete();
    clear_inputs();
  endtask

  task automatic test_fairness();
    logic [9:0] e;
    int k = 0;
    bit chg0 = 0, chg1 = 0;
    do_reset();
    rsp0_ready = 1; rsp1_ready = 1;
    req0_valid = 1; req0_dividend = 4'($urandom_range(15, 0)); req0_divisor = 4'($urandom_range(15, 1));
    req1_valid = 1; req1_dividend = 4'($urandom_range(15, 0)); req1_divisor = 4'($urandom_range(15, 1));
    @(negedge clock);
    if (req0_valid && req0_ready) chg0 = 1;
    for (int c = 0; c < 40 && k < 6; c++) begin
      @(posedge clock); #1;
      if (chg0) begin req0_dividend = 4'($urandom_range(15, 0)); req0_divisor = 4'($urandom_range(15, 0)); chg0 = 0; end
      if (chg1) begin req1_dividend = 4'($urandom_range(15, 0)); req1_divisor = 4'($urandom_range(15, 0)); chg1 = 0; end
      @(negedge clock);
      if (req0_valid && req0_ready) chg0 = 1;
      if (req1_valid && req1_ready) chg1 = 1;
      if (rsp0_valid || rsp1_valid) begin
        compared++;
        if (rsp0_valid === rsp1_valid || rsp1_valid !== k[0]) begin
          $display("FAIL fair_grant%0d: rsp valid %b%b want owner %0d", k, rsp0_valid, rsp1_valid, k[0]);
          mismatched++;
        end
        compared++;
        if (exp_q.size() == 0) begin $display("FAIL fair_result%0d: empty expected queue", k); mismatched++; end
        else begin
          e = exp_q.pop_front();
          if (obs() !== e) begin $display("FAIL fair_result%0d: got %h want %h", k, obs(), e); mismatched++; end
        end
        k++;
      end
    end
    compared++;
    if (k != 6) begin $display("FAIL fair_count: got %0d responses want 6", k); mismatched++; end
    @(posedge clock); #1;
    clear_inputs();
  endtask

  initial begin
    reset = 0;
    clear_inputs();
    test_reset();
    test_single();
    test_simultaneous();
    test_divzero();
    test_backpressure();
    test_reset_mid_calc();
    test_fairness();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
